// File: rtl/axi_burst_master.sv
// axi_burst_master: converts one core line request into a single AXI4 INCR burst.
// One transaction outstanding at a time. A request that is misaligned or would
// cross a 4 KiB page is completed locally with done_err=1 and issues no AXI traffic.
// Ports:
//   clk_i, rst_i                     clock, synchronous active-high reset
//   req_*                            core request handshake (we, addr, len = beats-1)
//   wd_* / rd_*                      core-side write/read beat streams
//   done_valid, done_err             one-cycle completion pulse with error flag
//   aw*/w*/b*/ar*/r*                 AXI4 master channels
module axi_burst_master #(
  parameter int unsigned ADDR_WTH = 32,
  parameter int unsigned DATA_WTH = 256,
  parameter int unsigned ID_WIDTH = 4,
  parameter int unsigned AXI_ID   = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  // core request
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WTH-1:0]   req_addr,
  input  logic [7:0]            req_len,
  // core write data
  input  logic                  wd_valid,
  output logic                  wd_ready,
  input  logic [DATA_WTH-1:0]   wd_data,
  input  logic [DATA_WTH/8-1:0] wd_strb,
  // core read data
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WTH-1:0]   rd_data,
  output logic                  rd_last,
  // completion
  output logic                  done_valid,
  output logic                  done_err,
  // AXI AW
  output logic [ID_WIDTH-1:0]   awid,
  output logic [ADDR_WTH-1:0]   awaddr,
  output logic [7:0]            awlen,
  output logic [2:0]            awsize,
  output logic [1:0]            awburst,
  output logic                  awlock,
  output logic [3:0]            awcache,
  output logic [2:0]            awprot,
  output logic [3:0]            awqos,
  output logic [3:0]            awregion,
  output logic                  awvalid,
  input  logic                  awready,
  // AXI W
  output logic [DATA_WTH-1:0]   wdata,
  output logic [DATA_WTH/8-1:0] wstrb,
  output logic                  wlast,
  output logic                  wvalid,
  input  logic                  wready,
  // AXI B
  input  logic                  bvalid,
  output logic                  bready,
  input  logic [1:0]            bresp,
  input  logic [ID_WIDTH-1:0]   bid,
  // AXI AR
  output logic [ID_WIDTH-1:0]   arid,
  output logic [ADDR_WTH-1:0]   araddr,
  output logic [7:0]            arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  output logic                  arlock,
  output logic [3:0]            arcache,
  output logic [2:0]            arprot,
  output logic [3:0]            arqos,
  output logic [3:0]            arregion,
  output logic                  arvalid,
  input  logic                  arready,
  // AXI R
  input  logic                  rvalid,
  output logic                  rready,
  input  logic [DATA_WTH-1:0]   rdata,
  input  logic [1:0]            rresp,
  input  logic [ID_WIDTH-1:0]   rid,
  input  logic                  rlast
);

  localparam int unsigned NB         = DATA_WTH / 8;
  localparam int unsigned SIZE       = $clog2(NB);
  localparam int unsigned PAGE_BYTES = 4096;
  localparam logic [ID_WIDTH-1:0] ID_VAL = ID_WIDTH'(AXI_ID);

  typedef enum logic [2:0] {
    S_IDLE, S_AR, S_R_DATA, S_AW, S_W_DATA, S_W_RESP, S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WTH-1:0]   addr_q, addr_d;
  logic [7:0]            len_q, len_d;
  logic [7:0]            beat_q, beat_d;
  logic                  err_q, err_d;
  logic                  wdone_q, wdone_d;
  logic                  awvalid_q, awvalid_d;
  logic                  arvalid_q, arvalid_d;
  logic                  bready_q, bready_d;
  logic                  req_ready_q, req_ready_d;
  logic                  done_valid_q, done_valid_d;

  logic                  w_phase, r_phase, w_hs, r_hs, bad_req;
  logic [7:0]            beat_inc;
  logic [31:0]           span;

  // Static AXI attributes
  assign awid     = ID_VAL;
  assign arid     = ID_VAL;
  assign awsize   = 3'(SIZE);
  assign arsize   = 3'(SIZE);
  assign awburst  = 2'b01;
  assign arburst  = 2'b01;
  assign awcache  = 4'b0011;
  assign arcache  = 4'b0011;
  assign awlock   = 1'b0;
  assign arlock   = 1'b0;
  assign awprot   = 3'b000;
  assign arprot   = 3'b000;
  assign awqos    = 4'b0000;
  assign arqos    = 4'b0000;
  assign awregion = 4'b0000;
  assign arregion = 4'b0000;

  // Registered request/handshake outputs
  assign awaddr     = addr_q;
  assign araddr     = addr_q;
  assign awlen      = len_q;
  assign arlen      = len_q;
  assign awvalid    = awvalid_q;
  assign arvalid    = arvalid_q;
  assign bready     = bready_q;
  assign req_ready  = req_ready_q;
  assign done_valid = done_valid_q;
  assign done_err   = err_q;

  // W may flow while AW is still pending, until the last beat has gone
  assign w_phase  = ((state_q == S_AW) && !wdone_q) || (state_q == S_W_DATA);
  assign wvalid   = w_phase & wd_valid;
  assign wd_ready = w_phase & wready;
  assign wdata    = wd_data;
  assign wstrb    = wd_strb;
  assign wlast    = (beat_q == len_q);
  assign w_hs     = wvalid & wready;

  // Read beats pass straight through to the core
  assign r_phase  = (state_q == S_R_DATA);
  assign rready   = r_phase & rd_ready;
  assign rd_valid = r_phase & rvalid;
  assign rd_data  = rdata;
  assign rd_last  = rlast;
  assign r_hs     = rvalid & rready;

  // Counter saturates instead of wrapping on an overlong read
  assign beat_inc = (beat_q == 8'hFF) ? beat_q : beat_q + 8'd1;

  // Request legality: NB-aligned and burst stays within one 4 KiB page
  assign span    = 32'(req_addr[11:0]) + (32'(req_len) + 32'd1) * NB;
  assign bad_req = (req_addr[SIZE-1:0] != '0) || (span > PAGE_BYTES);

  // Next-state and output decode
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    beat_d  = beat_q;
    err_d   = err_q;
    wdone_d = wdone_q;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          addr_d  = req_addr;
          len_d   = req_len;
          beat_d  = 8'd0;
          wdone_d = 1'b0;
          err_d   = 1'b0;
          if (bad_req) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = req_we ? S_AW : S_AR;
          end
        end
      end
      S_AR: begin
        if (arvalid_q && arready) state_d = S_R_DATA;
      end
      S_R_DATA: begin
        if (r_hs) begin
          beat_d = beat_inc;
          // rlast must coincide with the final counted beat
          if ((rresp != 2'b00) || (rid != ID_VAL) || (rlast != (beat_q == len_q))) err_d = 1'b1;
          if (rlast) state_d = S_DONE;
        end
      end
      S_AW: begin
        if (w_hs) begin
          beat_d = beat_inc;
          if (wlast) wdone_d = 1'b1;
        end
        if (awvalid_q && awready)
          state_d = (wdone_q || (w_hs && wlast)) ? S_W_RESP : S_W_DATA;
      end
      S_W_DATA: begin
        if (w_hs) begin
          beat_d = beat_inc;
          if (wlast) state_d = S_W_RESP;
        end
      end
      S_W_RESP: begin
        if (bvalid && bready_q) begin
          if ((bresp != 2'b00) || (bid != ID_VAL)) err_d = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    awvalid_d    = (state_d == S_AW);
    arvalid_d    = (state_d == S_AR);
    bready_d     = (state_d == S_W_RESP);
    req_ready_d  = (state_d == S_IDLE);
    done_valid_d = (state_d == S_DONE);
  end

  // State and output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      len_q        <= 8'd0;
      beat_q       <= 8'd0;
      err_q        <= 1'b0;
      wdone_q      <= 1'b0;
      awvalid_q    <= 1'b0;
      arvalid_q    <= 1'b0;
      bready_q     <= 1'b0;
      req_ready_q  <= 1'b1;
      done_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      beat_q       <= beat_d;
      err_q        <= err_d;
      wdone_q      <= wdone_d;
      awvalid_q    <= awvalid_d;
      arvalid_q    <= arvalid_d;
      bready_q     <= bready_d;
      req_ready_q  <= req_ready_d;
      done_valid_q <= done_valid_d;
    end
  end

endmodule

// File: tb/tb_axi_burst_master.sv
// Self-checking bench for axi_burst_master: acts as core and AXI slave, and
// predicts each transaction's outcome from the request and injected responses.
module tb_axi_burst_master;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 256;
  localparam int unsigned SW = DW / 8;
  localparam int unsigned IW = 4;

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [7:0]    req_len;
  logic          wd_valid, wd_ready;
  logic [DW-1:0] wd_data;
  logic [SW-1:0] wd_strb;
  logic          rd_valid, rd_ready, rd_last;
  logic [DW-1:0] rd_data;
  logic          done_valid, done_err;
  logic [IW-1:0] awid, arid, bid, rid;
  logic [AW-1:0] awaddr, araddr;
  logic [7:0]    awlen, arlen;
  logic [2:0]    awsize, arsize, awprot, arprot;
  logic [1:0]    awburst, arburst, bresp, rresp;
  logic          awlock, arlock;
  logic [3:0]    awcache, arcache, awqos, arqos, awregion, arregion;
  logic          awvalid, awready, arvalid, arready;
  logic [DW-1:0] wdata, rdata;
  logic [SW-1:0] wstrb;
  logic          wlast, wvalid, wready;
  logic          bvalid, bready;
  logic          rvalid, rready, rlast;

  axi_burst_master dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_len(req_len),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wd_strb(wd_strb),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .done_valid(done_valid), .done_err(done_err),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awqos(awqos),
    .awregion(awregion), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arqos(arqos),
    .arregion(arregion), .arvalid(arvalid), .arready(arready),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rid(rid),
    .rlast(rlast)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [511:0] got, input logic [511:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic idle_inputs();
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_len = 8'd0;
    wd_valid = 1'b0; wd_data = '0; wd_strb = '0; rd_ready = 1'b0;
    awready = 1'b0; arready = 1'b0; wready = 1'b0;
    bvalid = 1'b0; bresp = 2'b00; bid = '0;
    rvalid = 1'b0; rdata = '0; rresp = 2'b00; rid = '0; rlast = 1'b0;
  endtask

  // One request end to end. wr_period: wready every Nth cycle; aw_hold >= 0 holds
  // awready off until that many cycles after the last W beat; inj_beat >= 0 injects
  // a bad rresp on that read beat (or a bad bresp for a write); abort_beat >= 0
  // returns mid-read after that many beats.
  task automatic run_txn(input string name, input bit we, input logic [31:0] addr,
                         input int len, input int wr_period, input int aw_hold,
                         input int inj_beat, input int abort_beat);
    logic [DW-1:0] beats[$];
    logic [SW-1:0] strbs[$];
    int  span;
    bit  pre_err, exp_err;
    bit  accepted = 0, ax_done = 0, w_all = 0, b_done = 0, rv_hold = 0;
    int  acc_cyc = -1, ax_first = -1, w_all_cyc = -1, last_hs = -1;
    int  wi = 0, wrecv = 0, ri = 0, done_cnt = 0, done_cyc = -1;

    for (int i = 0; i <= len; i++) begin
      beats.push_back(rand_word());
      strbs.push_back(SW'($urandom));
    end
    span    = int'(addr[11:0]) + (len + 1) * int'(SW);
    pre_err = (addr[4:0] != 5'd0) || (span > 4096);
    exp_err = pre_err || (inj_beat >= 0 && inj_beat <= len);

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk_i);
      req_valid = !accepted;
      req_we    = we;
      req_addr  = addr;
      req_len   = 8'(len);
      wd_valid  = we && (wi <= len) && ($urandom_range(0, 3) != 0);
      if (wi <= len) begin
        wd_data = beats[wi];
        wd_strb = strbs[wi];
      end
      rd_ready = ($urandom_range(0, 3) != 0);
      arready  = 1'($urandom_range(0, 1));
      if (aw_hold < 0) awready = 1'($urandom_range(0, 1));
      else             awready = w_all && (cyc >= w_all_cyc + aw_hold);
      wready = (wr_period <= 1) ? 1'b1 : ((cyc % wr_period) == wr_period - 1);
      rvalid = !we && ax_done && (ri <= len) && (rv_hold || ($urandom_range(0, 2) != 0));
      rdata  = (ri <= len) ? beats[ri] : '0;
      rlast  = (ri == len);
      rid    = '0;
      rresp  = (ri == inj_beat) ? 2'b11 : 2'b00;
      bvalid = we && ax_done && w_all && !b_done;
      bresp  = (inj_beat >= 0) ? 2'b10 : 2'b00;
      bid    = '0;
      #1;

      // write response only after address accepted and all data sent
      if (bready) check_val({name, " b_order"}, {ax_done, w_all}, 2'b11);
      if (bvalid && bready) begin
        b_done  = 1;
        last_hs = cyc;
      end

      if (req_valid && req_ready) begin
        accepted = 1;
        acc_cyc  = cyc;
        if (pre_err) last_hs = cyc;
      end

      if ((we || pre_err) && arvalid) check_val({name, " spurious_arvalid"}, 1, 0);
      if ((!we || pre_err) && awvalid) check_val({name, " spurious_awvalid"}, 1, 0);

      if (!we && arvalid && !ax_done) begin
        if (ax_first < 0) begin
          ax_first = cyc;
          check_val({name, " ar_latency"}, cyc, acc_cyc + 1);
          check_val({name, " ar_fields"},
                    {araddr, arlen, arsize, arburst, arcache, arid, arprot, arlock, arqos, arregion},
                    {addr, 8'(len), 3'd5, 2'b01, 4'b0011, 4'd0, 3'd0, 1'b0, 4'd0, 4'd0});
        end
        if (arready) ax_done = 1;
      end
      if (we && awvalid && !ax_done) begin
        if (ax_first < 0) begin
          ax_first = cyc;
          check_val({name, " aw_latency"}, cyc, acc_cyc + 1);
          check_val({name, " aw_fields"},
                    {awaddr, awlen, awsize, awburst, awcache, awid, awprot, awlock, awqos, awregion},
                    {addr, 8'(len), 3'd5, 2'b01, 4'b0011, 4'd0, 3'd0, 1'b0, 4'd0, 4'd0});
        end
        if (awready) ax_done = 1;
      end

      if ((wd_valid && wd_ready) || (wvalid && wready))
        check_val({name, " w_hs_pair"}, wd_valid && wd_ready, wvalid && wready);
      if (wvalid && wready) begin
        if (wrecv <= len)
          check_val({name, " w_beat"}, {wdata, wstrb, wlast},
                    {beats[wrecv], strbs[wrecv], (wrecv == len)});
        else
          check_val({name, " w_extra"}, 1, 0);
        wrecv++;
        if (wrecv == len + 1) begin
          w_all     = 1;
          w_all_cyc = cyc;
        end
      end
      if (wd_valid && wd_ready) wi++;

      if (rvalid) check_val({name, " rready_pass"}, rready, rd_ready);
      if (rvalid && rready) begin
        check_val({name, " r_beat"}, {rd_data, rd_last, rd_valid}, {beats[ri], (ri == len), 1'b1});
        if (rlast) last_hs = cyc;
        ri++;
        rv_hold = 0;
        if (ri == abort_beat) return;
      end else begin
        rv_hold = rvalid;
      end

      if (done_valid) begin
        done_cnt++;
        done_cyc = cyc;
        check_val({name, " done_err"}, done_err, exp_err);
        check_val({name, " done_latency"}, cyc, last_hs + 1);
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
    end

    if (done_cyc < 0) check_val({name, " timeout"}, 1, 0);
    check_val({name, " done_count"}, done_cnt, 1);
    if (pre_err)  check_val({name, " no_axi_traffic"}, (ax_first >= 0), 0);
    else if (we)  check_val({name, " w_beats"}, wrecv, len + 1);
    else          check_val({name, " r_beats"}, ri, len + 1);
  endtask

  initial begin
    idle_inputs();
    rst_i = 1'b1;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    rd_ready = 1'b1;
    wready   = 1'b1;
    wd_valid = 1'b1;
    #1;
    check_val("reset_state",
              {req_ready, arvalid, awvalid, bready, done_valid, done_err, rready, wd_ready, wvalid},
              9'b1_0000_0000);
    @(negedge clk_i);
    rst_i = 1'b0;
    idle_inputs();

    run_txn("rd_len0",     1'b0, 32'h8000_0040, 0, 1, -1, -1, -1);
    run_txn("wr_len7_w4",  1'b1, 32'h8020_0000, 7, 4, -1, -1, -1);
    run_txn("wr_aw_late",  1'b1, 32'h8030_0000, 3, 1,  5, -1, -1);
    run_txn("rd_cross4k",  1'b0, 32'h8000_0F80, 7, 1, -1, -1, -1);
    run_txn("rd_edge4k",   1'b0, 32'h8000_0F00, 7, 1, -1, -1, -1);
    run_txn("wr_misalign", 1'b1, 32'h8000_0044, 0, 1, -1, -1, -1);
    run_txn("wr_bresp",    1'b1, 32'h8040_0000, 5, 1, -1,  3, -1);
    run_txn("rd_rresp",    1'b0, 32'h8050_0000, 5, 1, -1,  3, -1);

    // reset in the middle of a read burst
    run_txn("rd_abort",    1'b0, 32'h8060_0000, 5, 1, -1, -1,  2);
    @(negedge clk_i);
    rst_i    = 1'b1;
    rvalid   = 1'b1;
    rd_ready = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    check_val("mid_reset", {req_ready, rready, done_valid, done_err, arvalid, awvalid}, 6'b100000);
    idle_inputs();
    run_txn("rd_after_rst", 1'b0, 32'h8070_0000, 3, 1, -1, -1, -1);

    for (int t = 0; t < 40; t++) begin
      logic [31:0] a;
      int          l, inj;
      bit          w;
      w   = 1'($urandom_range(0, 1));
      l   = $urandom_range(0, 15);
      a   = 32'h8000_0000 | (32'($urandom_range(0, 4095)) & 32'hFFFF_FFE0);
      if ($urandom_range(0, 7) == 0) a = a + 32'd4;
      inj = ($urandom_range(0, 4) == 0) ? $urandom_range(0, l) : -1;
      run_txn($sformatf("rand%0d", t), w, a, l, $urandom_range(1, 3),
              $urandom_range(0, 4) - 1, inj, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
